// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array controller.
// Holds the FSM state encoding, the default array size and the PE data width.
package systolic_pkg;

  localparam int ARRAY_N = 4;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Zero-fill steps needed to flush the skewed wavefront out of an n x n array.
  function automatic int drain_len(input int n);
    return 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host <-> controller bundle: job control, weight/activation handshakes and array strobes.
// The stall_cycles counter exists only when SYSTOLIC_CTRL_PERF_EN is defined.
interface systolic_ctrl_if #(
  parameter int N     = systolic_pkg::ARRAY_N,
  parameter int CNT_W = 8
);
  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

  logic             start;
  logic             float_mode;
  logic [CNT_W-1:0] num_vec;
  logic             abort;
  logic             w_valid;
  logic             w_ready;
  logic             w_load_en;
  logic [ROW_W-1:0] w_row;
  logic             act_valid;
  logic             act_ready;
  logic             array_en;
  logic             inject_zero;
  logic             pe_float;
  logic [N-1:0]     ovf_in;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             ovf_sticky;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0]      stall_cycles;
`endif

  modport master (
    output start, float_mode, num_vec, abort, w_valid, act_valid, ovf_in,
    input  w_ready, w_load_en, w_row, act_ready, array_en, inject_zero,
    input  pe_float, out_valid, busy, done, ovf_sticky
`ifdef SYSTOLIC_CTRL_PERF_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  start, float_mode, num_vec, abort, w_valid, act_valid, ovf_in,
    output w_ready, w_load_en, w_row, act_ready, array_en, inject_zero,
    output pe_float, out_valid, busy, done, ovf_sticky
`ifdef SYSTOLIC_CTRL_PERF_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/systolic_ctrl_flex_counter.sv
// Up-counter with clear, enable and a programmable rollover value.
// roll_o marks the enabled step on which the count wraps back to zero.
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] roll_val_i,
  output logic [W-1:0] count_o,
  output logic         roll_o
);

  logic [W-1:0] count_q, count_d;

  assign roll_o  = en_i && (count_q == roll_val_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = roll_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N systolic array: weight load, activation stream, zero drain.
// Define SYSTOLIC_CTRL_PERF_EN to add the saturating stall_cycles counter.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N     = ARRAY_N,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  systolic_ctrl_if.slave bus
);

  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int DRN_W = $clog2(2 * N);
  localparam int FILL  = drain_len(N);

  state_e           state_q, state_d;
  logic             float_q, float_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic             ovf_q, ovf_d;

  logic             idle;
  logic             start_acc;
  logic             w_beat;
  logic             a_beat;
  logic             d_beat;
  logic             step;
  logic             result_ready;
  logic [N-1:0]     ovf_hit;
  logic             row_roll, vec_roll, drn_roll;
  logic [ROW_W-1:0] row_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic [DRN_W-1:0] drn_cnt;

  assign idle      = (state_q == ST_IDLE);
  assign start_acc = idle & bus.start;
  // abort wins over any handshake completing in the same cycle
  assign w_beat    = (state_q == ST_LOAD_W) & bus.w_valid & ~bus.abort;
  assign a_beat    = (state_q == ST_STREAM) & bus.act_valid & ~bus.abort;
  assign d_beat    = (state_q == ST_DRAIN) & ~bus.abort;
  assign step      = a_beat | d_beat;

  flex_counter #(.W(ROW_W)) u_row_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (idle),
    .en_i       (w_beat),
    .roll_val_i (ROW_W'(N - 1)),
    .count_o    (row_cnt),
    .roll_o     (row_roll)
  );

  flex_counter #(.W(CNT_W)) u_vec_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (idle),
    .en_i       (a_beat),
    .roll_val_i (num_vec_q - CNT_W'(1)),
    .count_o    (vec_cnt),
    .roll_o     (vec_roll)
  );

  flex_counter #(.W(DRN_W)) u_drn_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (idle),
    .en_i       (d_beat),
    .roll_val_i (DRN_W'(FILL - 1)),
    .count_o    (drn_cnt),
    .roll_o     (drn_roll)
  );

  // A result leaves the bottom row once FILL steps of the job have already occurred.
  always_comb begin
    result_ready = 1'b0;
    if (state_q == ST_STREAM) begin
      result_ready = (int'(vec_cnt) >= FILL);
    end else if (state_q == ST_DRAIN) begin
      result_ready = ((int'(num_vec_q) + int'(drn_cnt)) >= FILL);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ovf
    assign ovf_hit[gi] = step & bus.ovf_in[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.num_vec == '0) ? ST_DONE : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (bus.abort)    state_d = ST_IDLE;
        else if (row_roll) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (bus.abort)    state_d = ST_IDLE;
        else if (vec_roll) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.abort)    state_d = ST_IDLE;
        else if (drn_roll) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.w_ready     = 1'b0;
    bus.w_load_en   = 1'b0;
    bus.w_row       = '0;
    bus.act_ready   = 1'b0;
    bus.inject_zero = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      ST_LOAD_W: begin
        bus.w_ready   = 1'b1;
        bus.w_load_en = w_beat;
        bus.w_row     = row_cnt;
      end
      ST_STREAM: bus.act_ready   = 1'b1;
      ST_DRAIN:  bus.inject_zero = 1'b1;
      ST_DONE:   bus.done        = 1'b1;
      default: ;
    endcase
    bus.array_en  = step;
    bus.out_valid = step & result_ready;
    bus.busy      = ~idle;
    bus.pe_float  = float_q & ~idle;
  end

  always_comb begin
    float_d   = float_q;
    num_vec_d = num_vec_q;
    ovf_d     = ovf_q;
    if (start_acc) begin
      float_d   = bus.float_mode;
      num_vec_d = bus.num_vec;
      ovf_d     = 1'b0;
    end else if (|ovf_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      float_q   <= 1'b0;
      num_vec_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      float_q   <= float_d;
      num_vec_q <= num_vec_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ovf_sticky = ovf_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if ((state_q == ST_STREAM) && !bus.act_valid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: directed vector table, hand-written corner cases
// and randomized jobs checked against a job-level reference model.
module tb_systolic_ctrl;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();
  systolic_ctrl #(.N(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 idle, 1 weights, 2 stream, 3 drain, 4 done.
  int m_ph = 0, m_wb = 0, m_vd = 0, m_nv = 0, m_dl = 0, m_pulses = 0, m_stall = 0;
  bit m_fm = 0, m_sticky = 0;
  int n_pulse = 0, n_outv = 0, n_done = 0;

  typedef struct {
    logic        start;
    logic        fm;
    logic [7:0]  nv;
    logic        abort;
    logic        wv;
    logic        av;
    logic [3:0]  ovf;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(bit s, bit fm, int nv, bit ab, bit wv, bit av,
                              logic [3:0] ovf, logic [11:0] e);
    vec_t v;
    v.start = s; v.fm = fm; v.nv = 8'(nv); v.abort = ab;
    v.wv = wv; v.av = av; v.ovf = ovf; v.exp = e;
    return v;
  endfunction

  // {w_ready, w_load_en, w_row[1:0], act_ready, array_en, inject_zero, out_valid, busy, done, ovf_sticky, pe_float}
  function automatic logic [11:0] observe();
    return {bus.w_ready, bus.w_load_en, bus.w_row, bus.act_ready, bus.array_en,
            bus.inject_zero, bus.out_valid, bus.busy, bus.done, bus.ovf_sticky, bus.pe_float};
  endfunction

  function automatic logic [11:0] expected();
    logic ld, st, dr, en;
    ld = (m_ph == 1);
    st = (m_ph == 2);
    dr = (m_ph == 3);
    en = (st && bus.act_valid) || dr;
    return {ld, ld && bus.w_valid, ld ? 2'(m_wb) : 2'b00, st, en, dr,
            en && (m_pulses + 1 >= 2 * N - 1), m_ph != 0, m_ph == 4, m_sticky,
            (m_ph != 0) && m_fm};
  endfunction

  task automatic model_update(input bit en);
    if (rst) begin
      m_ph = 0; m_wb = 0; m_vd = 0; m_pulses = 0; m_sticky = 0; m_stall = 0;
      return;
    end
    if (en && (|bus.ovf_in)) m_sticky = 1;
    case (m_ph)
      0: if (bus.start) begin
        m_fm = bus.float_mode; m_sticky = 0; m_stall = 0; m_pulses = 0; m_wb = 0; m_vd = 0;
        if (bus.num_vec == 0) m_ph = 4;
        else begin m_nv = int'(bus.num_vec); m_ph = 1; end
      end
      1: if (bus.abort) m_ph = 0;
         else if (bus.w_valid) begin
           m_wb++;
           if (m_wb == N) begin m_wb = 0; m_ph = 2; end
         end
      2: begin
        if (!bus.act_valid && m_stall < 65535) m_stall++;
        if (bus.abort) m_ph = 0;
        else if (bus.act_valid) begin
          m_pulses++; m_vd++;
          if (m_vd == m_nv) begin m_ph = 3; m_dl = 2 * N - 2; end
        end
      end
      3: if (bus.abort) m_ph = 0;
         else begin
           m_pulses++; m_dl--;
           if (m_dl == 0) m_ph = 4;
         end
      default: m_ph = 0;
    endcase
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input string tag, input bit use_tbl, input logic [11:0] tbl_exp);
    logic [11:0] e, o, req;
    e = expected();
    req = use_tbl ? tbl_exp : e;
    @(negedge clk);
    o = observe();
    if (use_tbl || !(bus.abort && m_ph != 0)) begin
      tests++;
      if (o !== req) begin
        fails++;
        $display("FAIL %s: outputs=%b required=%b (model phase %0d)", tag, o, req, m_ph);
      end
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    tests++;
    if (bus.stall_cycles !== 16'(m_stall)) begin
      fails++;
      $display("FAIL %s_stall: stall_cycles=%0d required=%0d", tag, bus.stall_cycles, m_stall);
    end
`endif
    if (o[6]) n_pulse++;
    if (o[4]) n_outv++;
    if (o[2]) n_done++;
    @(posedge clk);
    model_update(e[6]);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.float_mode = 0; bus.num_vec = '0; bus.abort = 0;
    bus.w_valid = 0; bus.act_valid = 0; bus.ovf_in = '0;
  endtask

  task automatic finish_job(input string tag, input bit rnd);
    int guard;
    guard = 0;
    while (m_ph != 0 && guard < 2000) begin
      if (rnd) begin
        bus.start     = ($urandom_range(0, 7) == 0);
        bus.num_vec   = 8'($urandom);
        bus.w_valid   = ($urandom_range(0, 3) != 0);
        bus.act_valid = ($urandom_range(0, 3) != 0);
        bus.ovf_in    = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      end else begin
        bus.start = 0; bus.w_valid = 1; bus.act_valid = 1; bus.ovf_in = '0;
      end
      step(tag, 1'b0, '0);
      guard++;
    end
    if (guard >= 2000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: job still busy after %0d cycles, required idle", tag, guard);
    end
    clear_inputs();
  endtask

  task automatic run_job(input string tag, input int nv, input bit rnd);
    n_pulse = 0; n_outv = 0; n_done = 0;
    bus.start = 1; bus.num_vec = CNT_W'(nv); bus.float_mode = 1'($urandom_range(0, 1));
    bus.w_valid = 1; bus.act_valid = 1; bus.ovf_in = '0; bus.abort = 0;
    step({tag, "_start"}, 1'b0, '0);
    bus.start = 0;
    finish_job(tag, rnd);
    $display("[TB] job %s nv=%0d pulses=%0d results=%0d done=%0d", tag, nv, n_pulse, n_outv, n_done);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pat[5];
    int guard;
    pat = '{1, 0, 1, 0, 1};

    // Directed job: N=4, num_vec=3, overflow on pulse 5, restart clears sticky, abort in LOAD_W
    tbl[0]  = mk(1, 1, 3, 0, 1, 1, 4'b0000, 12'b0_0_00_0_0_0_0_0_0_0_0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b1_1_00_0_0_0_0_1_0_0_1);
    tbl[2]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b1_1_01_0_0_0_0_1_0_0_1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b1_1_10_0_0_0_0_1_0_0_1);
    tbl[4]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b1_1_11_0_0_0_0_1_0_0_1);
    tbl[5]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_1_1_0_0_1_0_0_1);
    tbl[6]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_1_1_0_0_1_0_0_1);
    tbl[7]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_1_1_0_0_1_0_0_1);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_0_1_1_0_1_0_0_1);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 4'b0010, 12'b0_0_00_0_1_1_0_1_0_0_1);
    tbl[10] = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_0_1_1_0_1_0_1_1);
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_0_1_1_1_1_0_1_1);
    tbl[12] = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_0_1_1_1_1_0_1_1);
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_0_1_1_1_1_0_1_1);
    tbl[14] = mk(0, 0, 0, 0, 1, 1, 4'b0000, 12'b0_0_00_0_0_0_0_1_1_1_1);
    tbl[15] = mk(1, 0, 5, 0, 0, 0, 4'b0000, 12'b0_0_00_0_0_0_0_0_0_1_0);
    tbl[16] = mk(1, 0, 5, 0, 0, 0, 4'b0000, 12'b1_0_00_0_0_0_0_1_0_0_0);
    tbl[17] = mk(0, 0, 0, 0, 1, 0, 4'b0000, 12'b1_1_00_0_0_0_0_1_0_0_0);
    tbl[18] = mk(0, 0, 0, 1, 0, 0, 4'b0000, 12'b1_0_01_0_0_0_0_1_0_0_0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 4'b0000, 12'b0_0_00_0_0_0_0_0_0_0_0);

    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    step("reset", 1'b0, '0);
    rst = 0;
    step("post_reset", 1'b0, '0);

    for (int i = 0; i < 20; i++) begin
      bus.start = tbl[i].start; bus.float_mode = tbl[i].fm; bus.num_vec = tbl[i].nv;
      bus.abort = tbl[i].abort; bus.w_valid = tbl[i].wv; bus.act_valid = tbl[i].av;
      bus.ovf_in = tbl[i].ovf;
      step($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
    end
    clear_inputs();

    // act_valid toggling during STREAM
    bus.start = 1; bus.num_vec = 8'd3; bus.w_valid = 1;
    step("tog_start", 1'b0, '0);
    bus.start = 0;
    for (int i = 0; i < N; i++) step("tog_w", 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      bus.act_valid = pat[i][0];
      step("tog_a", 1'b0, '0);
    end
    check("tog_drain_entered", int'(bus.inject_zero), 1);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("tog_stall", int'(bus.stall_cycles), 2);
`endif
    finish_job("tog", 1'b0);

    // abort together with the last weight beat
    n_done = 0;
    bus.start = 1; bus.num_vec = 8'd2; bus.w_valid = 1;
    step("abt_start", 1'b0, '0);
    bus.start = 0;
    for (int i = 0; i < N - 1; i++) step("abt_w", 1'b0, '0);
    bus.abort = 1;
    step("abt_cycle", 1'b0, '0);
    bus.abort = 0; bus.w_valid = 0;
    check("abt_busy", int'(bus.busy), 0);
    check("abt_act_ready", int'(bus.act_ready), 0);
    for (int i = 0; i < 3; i++) step("abt_idle", 1'b0, '0);
    check("abt_no_done", n_done, 0);

    // reset mid-DRAIN, then a clean job
    bus.start = 1; bus.num_vec = 8'd5; bus.w_valid = 1; bus.act_valid = 1;
    step("rst_start", 1'b0, '0);
    bus.start = 0;
    guard = 0;
    while (m_ph != 3 && guard < 100) begin step("rst_run", 1'b0, '0); guard++; end
    check("rst_reached_drain", m_ph, 3);
    step("rst_drain", 1'b0, '0);
    rst = 1;
    step("rst_edge", 1'b0, '0);
    rst = 0;
    check("rst_outputs", int'(observe()), 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("rst_stall", int'(bus.stall_cycles), 0);
`endif
    clear_inputs();
    run_job("after_rst", 3, 1'b0);
    check("after_rst_results", n_outv, 3);
    check("after_rst_pulses", n_pulse, 3 + 2 * N - 2);
    check("after_rst_done", n_done, 1);

    // zero-length job and start while busy
    run_job("zero", 0, 1'b0);
    check("zero_pulses", n_pulse, 0);
    check("zero_done", n_done, 1);

    // longest job: counters must not wrap
    run_job("max", 255, 1'b0);
    check("max_results", n_outv, 255);
    check("max_pulses", n_pulse, 255 + 2 * N - 2);

    for (int j = 0; j < 25; j++) begin
      int nv;
      nv = (j % 8 == 0) ? 0 : $urandom_range(1, 20);
      run_job($sformatf("rand%0d", j), nv, 1'b1);
      check($sformatf("rand%0d_results", j), n_outv, nv);
      check($sformatf("rand%0d_done", j), n_done, 1);
      step("rand_idle", 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (N x N PEs; 2..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning vector-count width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  job request, sampled only in IDLE.
REQ-006 SHALL have port float_mode  in  1  PE mode for the job (0 int8, 1 minifloat), latched at start.
REQ-007 SHALL have port num_vec  in  CNT_W  activation vectors in the job, latched at start.
REQ-008 SHALL have port abort  in  1  terminate the job.
REQ-009 SHALL have ports w_valid in 1 and w_ready out 1, the weight-row handshake.
REQ-010 SHALL have ports w_load_en out 1 and w_row out $clog2(N), the weight-row write strobe and index.
REQ-011 SHALL have ports act_valid in 1 and act_ready out 1, the activation handshake.
REQ-012 SHALL have port array_en  out  1  advance the array one step.
REQ-013 SHALL have port inject_zero  out  1  feed zeros to the array edge.
REQ-014 SHALL have port pe_float  out  1  float select to every PE.
REQ-015 SHALL have port ovf_in  in  N  per-column PE overflow, valid when array_en=1.
REQ-016 SHALL have port out_valid  out  1  bottom-row result valid.
REQ-017 SHALL have ports busy out 1, done out 1 and ovf_sticky out 1.

Function
REQ-018 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-019 In IDLE, start=1 with num_vec!=0 SHALL latch the configuration, clear ovf_sticky and go to LOAD_W; start with num_vec=0 SHALL go directly to DONE.
REQ-020 In LOAD_W, w_ready SHALL be 1; each beat (w_valid&w_ready) SHALL pulse w_load_en with w_row=0,1,...,N-1; the N-th beat SHALL move to STREAM next cycle.
REQ-021 In STREAM, act_ready SHALL be 1 and array_en SHALL equal act_valid; after num_vec beats the block SHALL move to DRAIN.
REQ-022 In DRAIN, array_en and inject_zero SHALL be 1 every cycle for exactly 2N-2 cycles, then the block SHALL move to DONE.
REQ-023 out_valid SHALL be 1 in the cycle of the k-th array_en pulse of the job (1-based) for 2N-1 <= k <= num_vec+2N-2, giving exactly num_vec results.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-025 ovf_sticky SHALL set when array_en=1 and |ovf_in=1, and SHALL hold until the next accepted start or reset.
REQ-026 pe_float SHALL hold the latched float_mode from LOAD_W through DONE, and SHALL be 0 in IDLE.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse; abort SHALL take priority over every handshake completing in the same cycle.
REQ-028 start outside IDLE SHALL be ignored; w_ready, act_ready, array_en, w_load_en, inject_zero and out_valid SHALL be 0 outside their states.
REQ-029 The vector and drain counters SHALL not wrap; num_vec=2^CNT_W-1 SHALL complete correctly.

Reset
REQ-030 rst=1 at a clock edge SHALL return the block to IDLE, zero all counters, and drive every output 0, including mid-job.

Configuration
REQ-031 With SYSTOLIC_CTRL_PERF_EN defined, the block SHALL add output stall_cycles (16 bits, saturating), counting STREAM cycles with act_valid=0 and clearing on an accepted start.
REQ-032 Without SYSTOLIC_CTRL_PERF_EN, the stall_cycles port and its counter SHALL be absent.

Structure
REQ-033 The state enum typedef SHALL be defined in the shared package systolic_pkg; the ARRAY_N default and DATA_W=8 constants SHALL be defined there as well.
REQ-034 The weight-row, vector and drain counts SHALL each use an instance of the sub-module flex_counter (clear, enable, rollover value, rollover flag).

Verification
REQ-035 N=4, num_vec=3, weights and activations always valid -> w_load_en on 4 cycles with w_row 0..3; 9 array_en pulses; out_valid on pulses 7,8,9; done 1 cycle; busy low next.
REQ-036 act_valid toggling 1,0,1,0,1 in STREAM (num_vec=3) -> array_en mirrors act_valid; DRAIN entered after the 3rd beat; stall_cycles=2 with PERF_EN.
REQ-037 ovf_in=4'b0010 on the 5th array_en pulse -> ovf_sticky=1 through DONE; cleared on the next start.
REQ-038 abort in the same cycle as the 4th weight beat -> IDLE next cycle; no STREAM, no done; busy=0.
REQ-039 rst asserted during DRAIN -> all outputs 0 next cycle; a new start then runs a full job normally.
REQ-040 start with num_vec=0 -> DONE next cycle with done=1; no array_en pulses; start while busy has no effect.
